data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, data word width; only 32 is supported.
REQ-002 SHALL have parameter ADDRESS_LEN, default 32, byte-address width.
REQ-003 SHALL have parameter MEM_DEPTH, default 64, number of DATA_LEN-bit words.
REQ-004 SHALL have parameter BASE_ADDR, default 1024, byte address of word 0.
REQ-005 SHALL have parameter WAIT_STATES, default 2, extra cycles per access, range 0-15.
REQ-006 SHALL have one clock and asynchronous active-high reset: clk input 1 rising-edge clock; rst input 1 async active-high reset.
REQ-007 SHALL have ALU_Res input ADDRESS_LEN, byte address.
REQ-008 SHALL have Val_Rm input DATA_LEN, store data; right-aligned for byte and halfword.
REQ-009 SHALL have MEM_W_EN input 1, store request, and MEM_R_EN input 1, load request.
REQ-010 SHALL have SIZE input 2: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-011 SHALL have SIGNED input 1, sign-extends byte and halfword loads.
REQ-012 SHALL have MEM_OUT output DATA_LEN, registered load data.
REQ-013 SHALL have READY output 1, one-cycle access-complete pulse.
REQ-014 SHALL have FREEZE output 1, pipeline stall request.
REQ-015 SHALL have ADDR_ERR output 1, registered fault flag; pulses with READY.

Function
REQ-016 SHALL use FSM states IDLE, WAIT, ACCESS.
REQ-017 IDLE: a cycle with MEM_W_EN or MEM_R_EN high is a request; the block latches address, data, SIZE, SIGNED and the op, then goes to WAIT if WAIT_STATES>0, else to ACCESS.
REQ-018 WAIT: the counter loads WAIT_STATES-1 and decrements each cycle; the block goes to ACCESS when the counter is 0.
REQ-019 ACCESS: the block performs the write or read, asserts READY for exactly this cycle, and returns to IDLE.
REQ-020 READY SHALL rise exactly WAIT_STATES+1 cycles after the request cycle.
REQ-021 FREEZE SHALL be combinational: (MEM_W_EN|MEM_R_EN) and not in ACCESS state; high in the request cycle, low in the READY cycle.
REQ-022 The requester holds its inputs until READY; inputs changing mid-access are ignored because latched values are used.
REQ-023 A request in the cycle immediately after READY starts a new access; back-to-back throughput is one access per WAIT_STATES+2 cycles.
REQ-024 When MEM_W_EN and MEM_R_EN are both high, the access is a write; MEM_OUT is unchanged.
REQ-025 Word index SHALL be (address-BASE_ADDR)>>2, using ADDRESS_LEN-bit unsigned arithmetic.
REQ-026 An address below BASE_ADDR or at or above BASE_ADDR+4*MEM_DEPTH is a fault.
REQ-027 A halfword access with addr[0]=1, a word access with addr[1:0]≠0, or SIZE=11 is a fault.
REQ-028 On a fault: no memory write; MEM_OUT is set to 0; ADDR_ERR=1 with READY; the access still takes full latency.
REQ-029 Byte order is little-endian; a byte store writes lane addr[1:0]; a halfword store writes lanes {addr[1],0}+1:0; other lanes are unchanged.
REQ-030 Loads SHALL select the same lane and zero-extend, or sign-extend when SIGNED=1; MEM_OUT is updated only in ACCESS of a read.
REQ-031 MEM_OUT SHALL hold its value between reads.

Reset
REQ-032 rst SHALL asynchronously force state IDLE, counter 0, READY 0, ADDR_ERR 0, MEM_OUT 0; FREEZE then follows REQ-021.
REQ-033 Reset during WAIT or ACCESS SHALL abort the access: no write occurs and no READY is issued.
REQ-034 Memory contents SHALL NOT be reset.

Verification (WAIT_STATES=2, BASE_ADDR=1024, MEM_DEPTH=64)
REQ-035 Word store 0xDEADBEEF @1024, then word load @1024: READY 3 cycles after each request; MEM_OUT=0xDEADBEEF; FREEZE high 3 cycles per access.
REQ-036 Byte store 0x80 @1029, then load byte @1029 with SIGNED=1 and then SIGNED=0: 0xFFFFFF80 then 0x00000080; word @1028 has only lane 1 changed.
REQ-037 Word load @1022, word load @1280, and halfword load @1027: each gives READY+ADDR_ERR=1 with MEM_OUT=0; memory unchanged.
REQ-038 Both enables high, Val_Rm=0x12345678 @1032, then read @1032: write performed; second read returns 0x12345678.
REQ-039 rst asserted one cycle into WAIT of a store 0xAAAAAAAA @1036 (old value 0x11111111): no READY; later load returns 0x11111111.
REQ-040 Back-to-back loads @1024 and @1028: second READY exactly 4 cycles after the first.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: wait-stated data memory with byte/halfword/word access, fault detection and pipeline freeze
module data_mem_ctrl #(
  parameter int DATA_LEN    = 32,
  parameter int ADDRESS_LEN = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDRESS_LEN-1:0] ALU_Res,
  input  logic [DATA_LEN-1:0]    Val_Rm,
  input  logic                   MEM_W_EN,
  input  logic                   MEM_R_EN,
  input  logic [1:0]             SIZE,
  input  logic                   SIGNED,
  output logic [DATA_LEN-1:0]    MEM_OUT,
  output logic                   READY,
  output logic                   FREEZE,
  output logic                   ADDR_ERR
);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [ADDRESS_LEN-1:0] LO = ADDRESS_LEN'(BASE_ADDR);
  localparam logic [ADDRESS_LEN-1:0] HI = ADDRESS_LEN'(BASE_ADDR + 4 * MEM_DEPTH);
  state_t state, nxt;
  logic [3:0] cnt, be;
  logic [ADDRESS_LEN-1:0] addr_q, a, off;
  logic [DATA_LEN-1:0] data_q, d, word, wd, ld;
  logic [1:0] size_q, sz;
  logic sgn_q, we_q, sg, we, req, idle, fault, go;
  logic [7:0] b8;
  logic [15:0] h16;
  logic [IW-1:0] idx;
  logic [DATA_LEN-1:0] mem [MEM_DEPTH];
  assign req = MEM_W_EN | MEM_R_EN;
  assign FREEZE = req && state != ACCESS;
  // In IDLE the live inputs are decoded so a zero-wait access can complete straight from the request
  always_comb begin
    idle  = state == IDLE;
    a     = idle ? ALU_Res : addr_q;
    d     = idle ? Val_Rm : data_q;
    sz    = idle ? SIZE : size_q;
    sg    = idle ? SIGNED : sgn_q;
    we    = idle ? MEM_W_EN : we_q;
    off   = a - LO;
    idx   = IW'(off >> 2);
    fault = a < LO || a >= HI || sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    word  = mem[idx];
    b8    = word[8 * a[1:0] +: 8];
    h16   = a[1] ? word[31:16] : word[15:0];
    ld    = fault ? '0 : sz == 2'b00 ? {{24{sg & b8[7]}}, b8} : sz == 2'b01 ? {{16{sg & h16[15]}}, h16} : word;
    wd    = sz == 2'b00 ? {4{d[7:0]}} : sz == 2'b01 ? {2{d[15:0]}} : d;
    be    = sz == 2'b00 ? 4'b0001 << a[1:0] : sz == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    nxt   = idle ? (req ? (WAIT_STATES > 0 ? WAIT : ACCESS) : IDLE) : state == WAIT ? (cnt == 4'd0 ? ACCESS : WAIT) : IDLE;
    go    = nxt == ACCESS;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      READY    <= 1'b0;
      ADDR_ERR <= 1'b0;
      MEM_OUT  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      size_q   <= '0;
      sgn_q    <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state    <= nxt;
      READY    <= go;
      ADDR_ERR <= go && fault;
      if (go && (fault || !we)) MEM_OUT <= ld;
      if (idle && req) begin
        addr_q <= ALU_Res;
        data_q <= Val_Rm;
        size_q <= SIZE;
        sgn_q  <= SIGNED;
        we_q   <= MEM_W_EN;
        cnt    <= 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
      end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  // The store commits on the edge leaving ACCESS, so a reset during the access suppresses it
  always_ff @(posedge clk)
    if (state == ACCESS && we_q && !fault)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed-vector bench for data_mem_ctrl at WAIT_STATES=2, BASE_ADDR=1024, MEM_DEPTH=64
module tb_data_mem_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] ALU_Res = '0, Val_Rm = '0;
  logic MEM_W_EN = 1'b0, MEM_R_EN = 1'b0, SIGNED = 1'b0;
  logic [1:0] SIZE = '0;
  logic [31:0] MEM_OUT;
  logic READY, FREEZE, ADDR_ERR;
  int vecs = 0, errs = 0, cyc = 0, t1 = 0, seen = 0;
  data_mem_ctrl dut (.clk(clk), .rst(rst), .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .MEM_W_EN(MEM_W_EN),
    .MEM_R_EN(MEM_R_EN), .SIZE(SIZE), .SIGNED(SIGNED), .MEM_OUT(MEM_OUT), .READY(READY),
    .FREEZE(FREEZE), .ADDR_ERR(ADDR_ERR));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Drives one request and runs until READY; leaves the inputs applied in the READY cycle
  task automatic acc(input string tag, input logic w, input logic r, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [1:0] sz, input logic sg);
    int n = 0, frz = 0;
    MEM_W_EN = w; MEM_R_EN = r; ALU_Res = adr; Val_Rm = dat; SIZE = sz; SIGNED = sg;
    #1;
    while (!READY && n < 10) begin
      if (FREEZE) frz++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, n, 3);
    chk({tag, " freeze cycles"}, frz, 3);
    chk({tag, " freeze in ready"}, {31'd0, FREEZE}, 0);
  endtask
  task automatic idle_cycle();
    MEM_W_EN = 1'b0; MEM_R_EN = 1'b0;
    @(posedge clk); #1;
  endtask
  initial begin
    #12;
    chk("rst ready", {31'd0, READY}, 0);
    chk("rst err", {31'd0, ADDR_ERR}, 0);
    chk("rst mem_out", MEM_OUT, 0);
    chk("rst freeze", {31'd0, FREEZE}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    acc("st word", 1, 0, 1024, 32'hDEADBEEF, 2'b10, 0);
    chk("st word err", {31'd0, ADDR_ERR}, 0);
    idle_cycle();
    acc("ld word", 0, 1, 1024, 0, 2'b10, 0);
    chk("ld word data", MEM_OUT, 32'hDEADBEEF);
    chk("ld word err", {31'd0, ADDR_ERR}, 0);
    idle_cycle();
    chk("mem_out hold", MEM_OUT, 32'hDEADBEEF);
    acc("st w1028", 1, 0, 1028, 32'h33221100, 2'b10, 0);
    idle_cycle();
    acc("st byte", 1, 0, 1029, 32'h12345680, 2'b00, 0);
    idle_cycle();
    acc("ld byte s", 0, 1, 1029, 0, 2'b00, 1);
    chk("ld byte s data", MEM_OUT, 32'hFFFFFF80);
    idle_cycle();
    acc("ld byte u", 0, 1, 1029, 0, 2'b00, 0);
    chk("ld byte u data", MEM_OUT, 32'h00000080);
    idle_cycle();
    acc("ld lanes", 0, 1, 1028, 0, 2'b10, 0);
    chk("byte lane only", MEM_OUT, 32'h33228000);
    idle_cycle();
    acc("st half", 1, 0, 1030, 32'h9999CAFE, 2'b01, 0);
    idle_cycle();
    acc("ld half s", 0, 1, 1030, 0, 2'b01, 1);
    chk("ld half s data", MEM_OUT, 32'hFFFFCAFE);
    idle_cycle();
    acc("ld half w", 0, 1, 1028, 0, 2'b10, 0);
    chk("half lanes", MEM_OUT, 32'hCAFE8000);
    idle_cycle();
    acc("ld 1022", 0, 1, 1022, 0, 2'b10, 0);
    chk("1022 err", {31'd0, ADDR_ERR}, 1);
    chk("1022 data", MEM_OUT, 0);
    idle_cycle();
    chk("err pulse", {31'd0, ADDR_ERR}, 0);
    acc("ld 1024b", 0, 1, 1024, 0, 2'b10, 0);
    idle_cycle();
    acc("ld 1280", 0, 1, 1280, 0, 2'b10, 0);
    chk("1280 err", {31'd0, ADDR_ERR}, 1);
    chk("1280 data", MEM_OUT, 0);
    idle_cycle();
    acc("ld half 1027", 0, 1, 1027, 0, 2'b01, 0);
    chk("1027 err", {31'd0, ADDR_ERR}, 1);
    chk("1027 data", MEM_OUT, 0);
    idle_cycle();
    acc("ld size3", 0, 1, 1024, 0, 2'b11, 0);
    chk("size3 err", {31'd0, ADDR_ERR}, 1);
    idle_cycle();
    acc("st misaligned", 1, 0, 1026, 32'hFFFFFFFF, 2'b10, 0);
    chk("st misaligned err", {31'd0, ADDR_ERR}, 1);
    idle_cycle();
    acc("st 1276", 1, 0, 1276, 32'h5A5A0001, 2'b10, 0);
    chk("1276 st err", {31'd0, ADDR_ERR}, 0);
    idle_cycle();
    acc("ld 1276", 0, 1, 1276, 0, 2'b10, 0);
    chk("1276 data", MEM_OUT, 32'h5A5A0001);
    idle_cycle();
    acc("ld 1024c", 0, 1, 1024, 0, 2'b10, 0);
    chk("unchanged 1024", MEM_OUT, 32'hDEADBEEF);
    idle_cycle();
    acc("both en", 1, 1, 1032, 32'h12345678, 2'b10, 0);
    chk("both en mem_out", MEM_OUT, 32'hDEADBEEF);
    idle_cycle();
    acc("ld 1032", 0, 1, 1032, 0, 2'b10, 0);
    chk("both en data", MEM_OUT, 32'h12345678);
    idle_cycle();
    acc("st 1036", 1, 0, 1036, 32'h11111111, 2'b10, 0);
    idle_cycle();
    MEM_W_EN = 1'b1; ALU_Res = 1036; Val_Rm = 32'hAAAAAAAA; SIZE = 2'b10; SIGNED = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort ready", {31'd0, READY}, 0);
    chk("abort mem_out", MEM_OUT, 0);
    MEM_W_EN = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (READY) seen++;
    end
    chk("abort no ready", seen, 0);
    acc("ld 1036", 0, 1, 1036, 0, 2'b10, 0);
    chk("abort no write", MEM_OUT, 32'h11111111);
    idle_cycle();
    acc("b2b first", 0, 1, 1024, 0, 2'b10, 0);
    chk("b2b first data", MEM_OUT, 32'hDEADBEEF);
    t1 = cyc;
    @(posedge clk); #1;
    acc("b2b second", 0, 1, 1028, 0, 2'b10, 0);
    chk("b2b spacing", cyc - t1, 4);
    chk("b2b second data", MEM_OUT, 32'hCAFE8000);
    idle_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
